// File: rtl/gsim_solver_param.sv
// gsim_solver_param
//   Parametrised Gauss-Seidel solver for a programmable number of NxN integer
//   systems A*x = b. Each matrix is streamed from the matrix memory one word
//   at a time (b vector, reciprocal-diagonal vector r, then rows of A). Every
//   returned row updates one x entry in the same edge using N parallel
//   multipliers and an adder tree. After the last iteration the x vector is
//   written to the result memory, one entry per cycle.
//
//   Optional build macro: GSIM_CONV_EN
//     Adds parameter CONV_THR and an early exit: an iteration whose largest
//     |x_new - x_old| is <= CONV_THR ends the solve for that matrix.
//
// Ports
//   i_clk           clock
//   i_reset         synchronous active-high reset
//   i_module_en     start / hold enable
//   i_matrix_num    number of matrices to solve (sampled in IDLE)
//   o_proc_done     all matrices solved, held while i_module_en=1
//   o_mem_rreq      matrix memory read request (held until i_mem_rrdy)
//   o_mem_addr      matrix memory read address
//   i_mem_rrdy      read request accepted this cycle
//   i_mem_dout      read word, lane k = bits [DW*k +: DW]
//   i_mem_dout_vld  read data valid
//   o_x_wen         result write strobe
//   o_x_addr        result address (m*N + k)
//   o_x_data        result value, signed Q(XW-XF).XF
module gsim_solver_param #(
    parameter int N    = 16,
    parameter int DW   = 16,
    parameter int RF   = 14,
    parameter int XW   = 32,
    parameter int XF   = 16,
    parameter int ITER = 16,
    parameter int MW   = 5,
    parameter int AW   = 10,
    parameter int XAW  = 9
`ifdef GSIM_CONV_EN
    ,
    parameter int CONV_THR = 0
`endif
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_module_en,
    input  logic [MW-1:0]   i_matrix_num,
    output logic            o_proc_done,
    output logic            o_mem_rreq,
    output logic [AW-1:0]   o_mem_addr,
    input  logic            i_mem_rrdy,
    input  logic [N*DW-1:0] i_mem_dout,
    input  logic            i_mem_dout_vld,
    output logic            o_x_wen,
    output logic [XAW-1:0]  o_x_addr,
    output logic [XW-1:0]   o_x_data
);

    localparam int RW = $clog2(N);
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW = XW + DW;
    localparam int SW = XW + DW + $clog2(N);

    localparam logic [RW-1:0]  LAST_ROW   = RW'(N - 1);
    localparam logic [IW-1:0]  LAST_IT    = IW'(ITER - 1);
    localparam logic [AW-1:0]  MAT_STRIDE = AW'(N + 2);
    localparam logic [XAW-1:0] X_STRIDE   = XAW'(N);

    localparam logic signed [SW-1:0] SAT_HI = {{(SW-XW+1){1'b0}}, {(XW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = {{(SW-XW+1){1'b1}}, {(XW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_B,
        S_LOAD_R,
        S_ROW,
        S_WRITE,
        S_DONE
    } state_t;

    // Clamp a wide signed value into the XW-bit x range.
    function automatic logic signed [XW-1:0] sat_xw(input logic signed [SW-1:0] v);
        if (v > SAT_HI)
            sat_xw = {1'b0, {(XW-1){1'b1}}};
        else if (v < SAT_LO)
            sat_xw = {1'b1, {(XW-1){1'b0}}};
        else
            sat_xw = v[XW-1:0];
    endfunction

    // Drop the RF reciprocal fraction bits with floor rounding, widened for sat_xw.
    function automatic logic signed [SW-1:0] scale_floor(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] sh;
        sh = p >>> RF;
        scale_floor = SW'(sh);
    endfunction

    state_t                 state;
    logic [MW-1:0]          m_q;
    logic [MW-1:0]          mnum_q;
    logic [IW-1:0]          it_q;
    logic [RW-1:0]          row_q;
    logic [RW-1:0]          k_q;
    logic [AW-1:0]          base_q;
    logic [XAW-1:0]         xbase_q;
    logic                   outst_q;
    logic signed [XW-1:0]   x_q [N];
    logic signed [DW-1:0]   b_q [N];
    logic signed [DW-1:0]   r_q [N];

    logic                   rd_vld;
    logic                   conv_hit;

    // Only data belonging to our own outstanding request counts.
    assign rd_vld = outst_q & i_mem_dout_vld;

    // Row update datapath: s = (b<<XF) - sum_{k!=row} a_k*x_k, then scale by r.
    logic signed [DW-1:0]   a_lane [N];
    logic signed [PW-1:0]   prod   [N];
    logic signed [SW-1:0]   s_full;
    logic signed [XW-1:0]   s_sat;
    logic signed [PW-1:0]   p_full;
    logic signed [XW-1:0]   x_new;

    always_comb begin
        s_full = SW'(b_q[row_q]) <<< XF;
        for (int k = 0; k < N; k++) begin
            a_lane[k] = i_mem_dout[DW*k +: DW];
            prod[k]   = PW'(a_lane[k]) * PW'(x_q[k]);
            // Diagonal lane carries no meaning; r replaces it.
            if (k != int'(row_q))
                s_full = s_full - SW'(prod[k]);
        end
        s_sat  = sat_xw(s_full);
        p_full = PW'(s_sat) * PW'(r_q[row_q]);
        x_new  = sat_xw(scale_floor(p_full));
    end

`ifdef GSIM_CONV_EN
    localparam int DXW = XW + 1;

    logic signed [XW:0] dlt;
    logic [XW:0]        dabs;
    logic [XW:0]        maxd_nxt;
    logic [XW:0]        maxd_q;

    always_comb begin
        dlt      = DXW'(x_new) - DXW'(x_q[row_q]);
        dabs     = dlt[XW] ? unsigned'(-dlt) : unsigned'(dlt);
        maxd_nxt = (dabs > maxd_q) ? dabs : maxd_q;
        conv_hit = (maxd_nxt <= DXW'(CONV_THR));
    end

    // Largest delta of the iteration in progress; cleared after the last row.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            maxd_q <= '0;
        else if (state == S_ROW && rd_vld)
            maxd_q <= (row_q == LAST_ROW) ? '0 : maxd_nxt;
    end
`else
    assign conv_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            m_q         <= '0;
            mnum_q      <= '0;
            it_q        <= '0;
            row_q       <= '0;
            k_q         <= '0;
            base_q      <= '0;
            xbase_q     <= '0;
            outst_q     <= 1'b0;
            o_proc_done <= 1'b0;
            o_mem_rreq  <= 1'b0;
            o_mem_addr  <= '0;
            o_x_wen     <= 1'b0;
            o_x_addr    <= '0;
            o_x_data    <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
                b_q[i] <= '0;
                r_q[i] <= '0;
            end
        end else begin
            o_x_wen <= 1'b0;

            // Read handshake: request drops after accept, one read in flight.
            if (o_mem_rreq && i_mem_rrdy) begin
                o_mem_rreq <= 1'b0;
                outst_q    <= 1'b1;
            end
            if (rd_vld)
                outst_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    o_proc_done <= 1'b0;
                    if (i_module_en) begin
                        if (i_matrix_num == '0) begin
                            state <= S_DONE;
                        end else begin
                            mnum_q     <= i_matrix_num;
                            m_q        <= '0;
                            it_q       <= '0;
                            row_q      <= '0;
                            base_q     <= '0;
                            xbase_q    <= '0;
                            for (int i = 0; i < N; i++)
                                x_q[i] <= '0;
                            o_mem_rreq <= 1'b1;
                            o_mem_addr <= '0;
                            state      <= S_LOAD_B;
                        end
                    end
                end

                S_LOAD_B: begin
                    if (rd_vld) begin
                        for (int i = 0; i < N; i++)
                            b_q[i] <= i_mem_dout[DW*i +: DW];
                        o_mem_rreq <= 1'b1;
                        o_mem_addr <= base_q + AW'(1);
                        state      <= S_LOAD_R;
                    end
                end

                S_LOAD_R: begin
                    if (rd_vld) begin
                        for (int i = 0; i < N; i++)
                            r_q[i] <= i_mem_dout[DW*i +: DW];
                        o_mem_rreq <= 1'b1;
                        o_mem_addr <= base_q + AW'(2);
                        state      <= S_ROW;
                    end
                end

                S_ROW: begin
                    if (rd_vld) begin
                        x_q[row_q] <= x_new;
                        if (row_q == LAST_ROW) begin
                            row_q <= '0;
                            if (it_q == LAST_IT || conv_hit) begin
                                it_q  <= '0;
                                k_q   <= '0;
                                state <= S_WRITE;
                            end else begin
                                it_q       <= it_q + IW'(1);
                                o_mem_rreq <= 1'b1;
                                o_mem_addr <= base_q + AW'(2);
                            end
                        end else begin
                            row_q      <= row_q + RW'(1);
                            o_mem_rreq <= 1'b1;
                            o_mem_addr <= base_q + AW'(row_q) + AW'(3);
                        end
                    end
                end

                S_WRITE: begin
                    o_x_wen  <= 1'b1;
                    o_x_addr <= xbase_q + XAW'(k_q);
                    o_x_data <= x_q[k_q];
                    if (k_q == LAST_ROW) begin
                        k_q <= '0;
                        if (m_q == mnum_q - MW'(1)) begin
                            state <= S_DONE;
                        end else begin
                            m_q        <= m_q + MW'(1);
                            base_q     <= base_q + MAT_STRIDE;
                            xbase_q    <= xbase_q + X_STRIDE;
                            // Nonblocking: this cycle's write still sees the old x.
                            for (int i = 0; i < N; i++)
                                x_q[i] <= '0;
                            o_mem_rreq <= 1'b1;
                            o_mem_addr <= base_q + MAT_STRIDE;
                            state      <= S_LOAD_B;
                        end
                    end else begin
                        k_q <= k_q + RW'(1);
                    end
                end

                S_DONE: begin
                    if (i_module_en) begin
                        o_proc_done <= 1'b1;
                    end else begin
                        o_proc_done <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_solver_param.sv
// Testbench for gsim_solver_param (N=4, ITER=4). A matrix-memory responder with
// optional random accept stalls and read latency feeds the DUT; results are
// compared against a plain-arithmetic Gauss-Seidel model of the same systems.
module tb_gsim_solver_param;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int RF   = 14;
    localparam int XW   = 32;
    localparam int XF   = 16;
    localparam int ITER = 4;
    localparam int MW   = 5;
    localparam int AW   = 10;
    localparam int XAW  = 9;
`ifdef GSIM_CONV_EN
    localparam bit CONV = 1'b1;
`else
    localparam bit CONV = 1'b0;
`endif
    localparam longint CONV_THR = 0;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [MW-1:0]   num;
    logic            done;
    logic            rreq;
    logic [AW-1:0]   addr;
    logic            rrdy;
    logic [N*DW-1:0] dout;
    logic            vld;
    logic            wen;
    logic [XAW-1:0]  xaddr;
    logic [XW-1:0]   xdata;

    gsim_solver_param #(
        .N(N), .DW(DW), .RF(RF), .XW(XW), .XF(XF), .ITER(ITER),
        .MW(MW), .AW(AW), .XAW(XAW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_module_en    (en),
        .i_matrix_num   (num),
        .o_proc_done    (done),
        .o_mem_rreq     (rreq),
        .o_mem_addr     (addr),
        .i_mem_rrdy     (rrdy),
        .i_mem_dout     (dout),
        .i_mem_dout_vld (vld),
        .o_x_wen        (wen),
        .o_x_addr       (xaddr),
        .o_x_data       (xdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus matrices and memory image
    int              am [8][N][N];
    int              bm [8][N];
    int              rm [8][N];
    longint          xexp [8][N];
    logic [N*DW-1:0] mem [1024];

    // Observation
    int             acc_q [$];
    int             wr_addr_q [$];
    logic [XW-1:0]  wr_data_q [$];
    int             cyc = 0;
    int             last_wr_cyc = -1;
    int             done_rise_cyc = -1;
    int             viol = 0;
    bit             stall_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder and output monitor, all on the falling edge.
    initial begin
        int lat;
        int stall;
        int ra;
        bit prev_stall;
        bit done_prev;
        logic [AW-1:0] prev_addr;
        lat = 0; stall = 0; ra = 0; prev_stall = 1'b0; done_prev = 1'b0; prev_addr = '0;
        rrdy = 1'b0; vld = 1'b0; dout = '0;
        forever begin
            @(negedge clk);
            cyc++;
            vld = 1'b0;
            if (rst) begin
                lat = 0;
                prev_stall = 1'b0;
                rrdy = 1'b0;
            end else begin
                if (rreq && lat > 0) viol++;
                if (prev_stall && !(rreq && addr == prev_addr)) viol++;
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin
                        vld  = 1'b1;
                        dout = mem[ra];
                    end
                end
                if (stall_mode) begin
                    if (stall > 0) begin
                        rrdy = 1'b0;
                        stall--;
                    end else if ($urandom_range(0, 3) == 0) begin
                        rrdy  = 1'b0;
                        stall = $urandom_range(0, 4);
                    end else begin
                        rrdy = 1'b1;
                    end
                end else begin
                    rrdy = 1'b1;
                end
                if (rreq && rrdy) begin
                    ra = int'(addr);
                    acc_q.push_back(int'(addr));
                    lat = stall_mode ? int'($urandom_range(1, 4)) : 1;
                end
                prev_stall = rreq && !rrdy;
                prev_addr  = addr;
            end
            if (wen) begin
                wr_addr_q.push_back(int'(xaddr));
                wr_data_q.push_back(xdata);
                last_wr_cyc = cyc;
            end
            if (done && !done_prev) done_rise_cyc = cyc;
            done_prev = done;
        end
    end

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Gauss-Seidel reference: plain integer arithmetic on the stored systems.
    task automatic model_solve(input int m, output int nit);
        longint x [N];
        longint s, p, d, maxd;
        for (int i = 0; i < N; i++) x[i] = 0;
        nit = 0;
        for (int it = 0; it < ITER; it++) begin
            maxd = 0;
            for (int i = 0; i < N; i++) begin
                s = longint'(bm[m][i]) <<< XF;
                for (int k = 0; k < N; k++)
                    if (k != i) s = s - longint'(am[m][i][k]) * x[k];
                s = sat32(s);
                p = sat32((s * longint'(rm[m][i])) >>> RF);
                d = p - x[i];
                if (d < 0) d = -d;
                if (d > maxd) maxd = d;
                x[i] = p;
            end
            nit = it + 1;
            if (CONV && maxd <= CONV_THR) break;
        end
        for (int k = 0; k < N; k++) xexp[m][k] = x[k];
    endtask

    task automatic set_diag(input int m, input int b0, input int b1, input int b2, input int b3);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) am[m][i][k] = (i == k) ? 2 : 0;
            rm[m][i] = 32'h2000;
        end
        bm[m][0] = b0; bm[m][1] = b1; bm[m][2] = b2; bm[m][3] = b3;
    endtask

    task automatic rand_mat(input int m, input bit dominant);
        int dg;
        for (int i = 0; i < N; i++) begin
            if (dominant) begin
                dg = $urandom_range(16, 31);
                for (int k = 0; k < N; k++)
                    am[m][i][k] = (i == k) ? dg : int'($urandom_range(0, 6)) - 3;
                rm[m][i] = (1 << RF) / dg;
                bm[m][i] = int'($urandom_range(0, 2000)) - 1000;
            end else begin
                for (int k = 0; k < N; k++)
                    am[m][i][k] = int'($urandom_range(0, 65535)) - 32768;
                rm[m][i] = int'($urandom_range(0, 65535)) - 32768;
                bm[m][i] = int'($urandom_range(0, 65535)) - 32768;
            end
        end
    endtask

    task automatic build_mem(input int nmat);
        logic [N*DW-1:0] w;
        int base;
        for (int m = 0; m < nmat; m++) begin
            base = m * (N + 2);
            for (int k = 0; k < N; k++) w[DW*k +: DW] = DW'(bm[m][k]);
            mem[base] = w;
            for (int k = 0; k < N; k++) w[DW*k +: DW] = DW'(rm[m][k]);
            mem[base + 1] = w;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) w[DW*k +: DW] = DW'(am[m][i][k]);
                mem[base + 2 + i] = w;
            end
        end
    endtask

    task automatic clear_obs();
        acc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        last_wr_cyc   = -1;
        done_rise_cyc = -1;
        viol          = 0;
    endtask

    task automatic run_job(input int nmat, input string tag);
        int n;
        clear_obs();
        @(negedge clk);
        num = MW'(nmat);
        en  = 1'b1;
        n   = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_done_clr"}, 64'(done), 64'(0));
    endtask

    task automatic check_job(input int nmat, input string tag);
        int nit;
        int exp_acc [$];
        int base;
        int j;
        logic [XW-1:0] e32;
        longint xe;
        for (int m = 0; m < nmat; m++) begin
            model_solve(m, nit);
            base = m * (N + 2);
            exp_acc.push_back(base);
            exp_acc.push_back(base + 1);
            for (int it = 0; it < nit; it++)
                for (int i = 0; i < N; i++) exp_acc.push_back(base + 2 + i);
        end
        chk({tag, "_n_accepts"}, 64'(acc_q.size()), 64'(exp_acc.size()));
        for (j = 0; j < exp_acc.size() && j < acc_q.size(); j++)
            chk({tag, "_acc_addr"}, 64'(acc_q[j]), 64'(exp_acc[j]));
        chk({tag, "_n_writes"}, 64'(wr_addr_q.size()), 64'(nmat * N));
        for (int m = 0; m < nmat; m++)
            for (int k = 0; k < N; k++) begin
                j = m * N + k;
                if (j < wr_addr_q.size()) begin
                    xe  = xexp[m][k];
                    e32 = xe[31:0];
                    chk({tag, "_wr_addr"}, 64'(wr_addr_q[j]), 64'(j));
                    chk({tag, "_wr_data"}, {32'd0, wr_data_q[j]}, {32'd0, e32});
                end
            end
        chk({tag, "_handshake"}, 64'(viol), 64'(0));
        if (nmat > 0)
            chk({tag, "_done_lat"}, 64'(done_rise_cyc), 64'(last_wr_cyc + 1));
    endtask

    task automatic check_scen1(input string tag);
        chk({tag, "_x0"}, {32'd0, wr_data_q.size() > 0 ? wr_data_q[0] : 32'hDEAD}, 64'h00020000);
        chk({tag, "_x1"}, {32'd0, wr_data_q.size() > 1 ? wr_data_q[1] : 32'hDEAD}, 64'hFFFD0000);
        chk({tag, "_x2"}, {32'd0, wr_data_q.size() > 2 ? wr_data_q[2] : 32'hDEAD}, 64'h00050000);
        chk({tag, "_x3"}, {32'd0, wr_data_q.size() > 3 ? wr_data_q[3] : 32'hDEAD}, 64'h00000000);
        chk({tag, "_acc_cnt"}, 64'(acc_q.size()), CONV ? 64'(2 + 2 * N) : 64'(2 + ITER * N));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rreq"},  64'(rreq),  64'(0));
        chk({tag, "_addr"},  64'(addr),  64'(0));
        chk({tag, "_wen"},   64'(wen),   64'(0));
        chk({tag, "_xaddr"}, 64'(xaddr), 64'(0));
        chk({tag, "_xdata"}, 64'(xdata), 64'(0));
        chk({tag, "_done"},  64'(done),  64'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; num = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Diagonal system
        set_diag(0, 4, -6, 10, 0);
        build_mem(1);
        run_job(1, "diag");
        check_job(1, "diag");
        check_scen1("diag");

        // Positive and negative saturation of x0; diagonal lane of row 0 ignored
        set_diag(0, 32767, 1, 2, 3);
        am[0][0][0] = 5;
        rm[0][0] = 32'h7FFF;
        build_mem(1);
        run_job(1, "satp");
        check_job(1, "satp");
        chk("satp_x0", {32'd0, wr_data_q.size() > 0 ? wr_data_q[0] : 32'hDEAD}, 64'h7FFFFFFF);
        bm[0][0] = -32768;
        build_mem(1);
        run_job(1, "satn");
        check_job(1, "satn");
        chk("satn_x0", {32'd0, wr_data_q.size() > 0 ? wr_data_q[0] : 32'hDEAD}, 64'h80000000);

        // Stalls and random latency on the diagonal system
        stall_mode = 1'b1;
        set_diag(0, 4, -6, 10, 0);
        build_mem(1);
        run_job(1, "stall");
        check_job(1, "stall");
        check_scen1("stall");

        // Three random matrices with stalls
        rand_mat(0, 1'b1);
        rand_mat(1, 1'b0);
        rand_mat(2, 1'b1);
        build_mem(3);
        run_job(3, "multi");
        check_job(3, "multi");

        // Zero matrices: done with no reads or writes
        stall_mode = 1'b0;
        run_job(0, "zero");
        check_job(0, "zero");

        // Reset in the middle of the row phase, then rerun
        set_diag(0, 4, -6, 10, 0);
        build_mem(1);
        clear_obs();
        @(negedge clk);
        num = MW'(1);
        en  = 1'b1;
        n   = 0;
        while (acc_q.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached_row", 64'(acc_q.size() >= 5), 64'(1));
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_hold_rreq", 64'(rreq), 64'(0));
        chk("midrst_hold_wen",  64'(wen),  64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_job(1, "rerun");
        check_job(1, "rerun");
        check_scen1("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gsim_solver_param.md
Name: gsim_solver_param

Overview:
Parametrised successor of the fixed 16x16 Gauss-Seidel iterative solver. Solves A·x = b for a programmable number of NxN systems held in matrix memory. Each row update runs in one cycle using N parallel multipliers and an adder tree. Writes the final x vector to the result memory. Sits between the matrix SRAM read port and the x result SRAM write port, under the same top-level enable/done control.

Parameters:
N, 16, matrix dimension (2..32)
DW, 16, width of signed integer A and b entries and of the reciprocal-diagonal entries
RF, 14, fraction bits of reciprocal-diagonal entries r_i = 1/a_ii
XW, 32, width of signed x values
XF, 16, fraction bits of x
ITER, 16, Gauss-Seidel iterations per matrix (>=1)
MW, 5, width of matrix-count input
AW, 10, matrix memory address width
XAW, 9, result memory address width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_module_en  in  1  start / hold enable
i_matrix_num  in  MW  number of matrices to solve
o_proc_done  out  1  all matrices solved
o_mem_rreq  out  1  read request
o_mem_addr  out  AW  read address
i_mem_rrdy  in  1  request accepted this cycle
i_mem_dout  in  N*DW  read word; lane k = bits [DW*k +: DW]
i_mem_dout_vld  in  1  read data valid
o_x_wen  out  1  result write strobe
o_x_addr  out  XAW  result address
o_x_data  out  XW  result value, signed Q(XW-XF).XF

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters 0; x, b, r registers 0. Reset mid-operation aborts the current work on the next edge with no further requests or writes.
- Memory layout: matrix m occupies N+2 words starting at base = m*(N+2).
  - Word base+0: b vector.
  - Word base+1: r vector.
  - Word base+2+i: row i of A. The diagonal lane is ignored.
- Read handshake:
  - At most one read outstanding.
  - o_mem_rreq and o_mem_addr are held stable until a cycle with i_mem_rrdy=1, which is the accept.
  - o_mem_rreq drops the following cycle and the block waits for i_mem_dout_vld. Latency is arbitrary, 1 cycle or more.
  - A new request may be raised in the cycle after vld.
  - vld with nothing outstanding is ignored.
- States:
  - IDLE: i_module_en=1 with i_matrix_num=0 goes to DONE. Otherwise load m=0, it=0, row=0 and go to LOAD_B.
  - LOAD_B: read base+0 and latch b on vld, then go to LOAD_R. x is cleared to 0 on entry.
  - LOAD_R: read base+1 and latch r on vld, then go to ROW.
  - ROW: read base+2+row. On vld, update x[row] in the same edge. Then row++.
    - At row=N-1: row=0, it++.
    - At it=ITER-1: go to WRITE.
  - WRITE: one write per cycle, no reads. o_x_wen=1, o_x_addr=m*N+k, o_x_data=x[k], for k=0..N-1 (registered). Then either m++ and go to LOAD_B, or go to DONE when m=i_matrix_num-1.
  - DONE: o_proc_done=1 while i_module_en=1. i_module_en=0 returns to IDLE with done deasserted next cycle.
- i_module_en deassertion before DONE is ignored. i_matrix_num is sampled in IDLE only.
- Row arithmetic (Gauss-Seidel: uses x values already updated this iteration):
  - s = (b_i << XF) − Σ_{k≠i} a_ik·x_k, at full width XW+DW+clog2(N). No intermediate truncation.
  - s_sat = saturate(s) to XW bits.
  - p = s_sat · r_i, arithmetic-shifted right by RF (floor).
  - x_i = saturate(p) to XW bits.
  - Saturation limits: 2^(XW−1)−1 and −2^(XW−1).
- Reads per matrix: 2 + ITER·N. Minimum cycles per row: 2.
- Address arithmetic wraps modulo 2^AW and 2^XAW. Callers keep i_matrix_num·(N+2) ≤ 2^AW.

Optional Feature:
GSIM_CONV_EN
- With the macro: parameter CONV_THR (default 0).
  - Per iteration, track the max |x_new − x_old| over all rows.
  - At the end of any iteration where that max ≤ CONV_THR, go straight to WRITE. Remaining iterations are skipped.
  - ITER remains the upper bound on iterations.
- Without the macro: exactly ITER iterations always. No delta logic is synthesised.

Test Plan:
- Diagonal solve, N=4, ITER=4: all off-diagonals 0, a_ii=2, r=0x2000, b=[4,−6,10,0] → writes at addr 0..3 with data 0x00020000, 0xFFFD0000, 0x00050000, 0x00000000; o_proc_done=1 one cycle after the last write.
- Saturation: N=4, b0=32767, r0=0x7FFF, row0 otherwise 0 → x0 = o_x_data = 0x7FFFFFFF; b0=−32768 → 0x80000000.
- Stall: random i_mem_rrdy low runs up to 5 cycles and vld latency 1–4 → identical results; o_mem_addr is stable while rreq=1 and rrdy=0; exactly 2+ITER·N accepts per matrix.
- Multi-matrix, i_matrix_num=3, N=4 → read bases 0, 6, 12; write addresses 0–3, 4–7, 8–11; i_matrix_num=0 → done with no reads.
- Reset asserted mid-ROW → all outputs 0 on the next edge; a rerun after release gives the scenario-1 results.
- GSIM_CONV_EN, CONV_THR=0, diagonal system → 2+2N read accepts (iteration 2 has delta 0), then N writes with the scenario-1 values.
